// File: rtl/dreimann_rules_if.sv
// Signal bundle between the dice controllers / display stage and the DreiMann rules engine.
// The master side drives the dice and game control; the slave side is the rules engine.
interface dreimann_rules_if;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic       rolled1;
  logic       rolled2;
  logic       new_game;
  logic [2:0] event_code;
  logic       event_valid;
  logic [3:0] sum;
  logic       dreimann;
  logic [7:0] round_cnt;
  logic [3:0] dm_drinks;
  logic       busy;

  modport master (
    output dice1, dice2, rolled1, rolled2, new_game,
    input  event_code, event_valid, sum, dreimann, round_cnt, dm_drinks, busy
  );

  modport slave (
    input  dice1, dice2, rolled1, rolled2, new_game,
    output event_code, event_valid, sum, dreimann, round_cnt, dm_drinks, busy
  );
endinterface

// File: rtl/dreimann_rules.sv
// DreiMann rules engine: pairs two die results into a throw, classifies it and tracks the
// Dreimann, round and drink counters. All outputs are registered.
module dreimann_rules #(
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input logic              clk,
  input logic              rst_n,
  dreimann_rules_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Leaving HALF when the counter is here makes IDLE land exactly TIMEOUT_CYC cycles after capture.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {StIdle, StHalf, StEval} state_e;

  typedef enum logic [2:0] {
    EvNone       = 3'd0,
    EvNewDm      = 3'd1,
    EvDmDrinks   = 3'd2,
    EvDreiPasch  = 3'd3,
    EvPasch      = 3'd4,
    EvLeftDrinks = 3'd5,
    EvRightDrinks= 3'd6,
    EvInvalid    = 3'd7
  } event_e;

  state_e          state_q, state_d;
  logic [2:0]      cap_a_q, cap_a_d;
  logic [2:0]      cap_b_q, cap_b_d;
  logic            got1_q, got1_d;
  logic            got2_q, got2_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic [3:0]      sum_q, sum_d;
  logic            dm_q, dm_d;
  logic [7:0]      rc_q, rc_d;
  logic [3:0]      drinks_q, drinks_d;
  logic            busy_q, busy_d;

  logic            invalid;
  logic            a3, b3;
  logic [3:0]      sum_ab;
  logic [7:0]      rc_inc;
  logic [3:0]      drinks_inc;

  always_comb begin
    invalid    = (cap_a_q == 3'd0) || (cap_a_q == 3'd7) || (cap_b_q == 3'd0) || (cap_b_q == 3'd7);
    a3         = (cap_a_q == 3'd3);
    b3         = (cap_b_q == 3'd3);
    sum_ab     = {1'b0, cap_a_q} + {1'b0, cap_b_q};
    rc_inc     = (rc_q == 8'hFF) ? rc_q : rc_q + 8'd1;
    drinks_inc = (drinks_q == 4'hF) ? drinks_q : drinks_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    got1_d   = got1_q;
    got2_d   = got2_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    sum_d    = sum_q;
    dm_d     = dm_q;
    rc_d     = rc_q;
    drinks_d = drinks_q;

    if (bus.new_game) begin
      state_d  = StIdle;
      cap_a_d  = '0;
      cap_b_d  = '0;
      got1_d   = 1'b0;
      got2_d   = 1'b0;
      cnt_d    = '0;
      code_d   = EvNone;
      sum_d    = '0;
      dm_d     = 1'b0;
      rc_d     = '0;
      drinks_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StEval: begin
          if (state_q == StEval) begin
            valid_d = 1'b1;
            if (invalid) begin
              code_d = EvInvalid;
            end else begin
              sum_d = sum_ab;
              rc_d  = rc_inc;
              if (a3 && b3) begin
                code_d   = EvDreiPasch;
                dm_d     = 1'b1;
                drinks_d = drinks_inc;
              end else if (a3 != b3) begin
                if (dm_q) begin
                  code_d   = EvDmDrinks;
                  drinks_d = drinks_inc;
                end else begin
                  code_d = EvNewDm;
                  dm_d   = 1'b1;
                end
              end else if (sum_ab == 4'd3) begin
                if (dm_q) begin
                  code_d   = EvDmDrinks;
                  drinks_d = drinks_inc;
                end else begin
                  code_d = EvNone;
                end
              end else if (cap_a_q == cap_b_q) begin
                code_d = EvPasch;
              end else if (sum_ab == 4'd7) begin
                code_d = EvLeftDrinks;
              end else if (sum_ab == 4'd9) begin
                code_d = EvRightDrinks;
              end else begin
                code_d = EvNone;
              end
            end
          end
          // Pulses seen in IDLE or EVAL start the next throw from scratch.
          got1_d  = bus.rolled1;
          got2_d  = bus.rolled2;
          cap_a_d = bus.rolled1 ? bus.dice1 : 3'd0;
          cap_b_d = bus.rolled2 ? bus.dice2 : 3'd0;
          cnt_d   = '0;
          if (bus.rolled1 && bus.rolled2) begin
            state_d = StEval;
          end else if (bus.rolled1 || bus.rolled2) begin
            state_d = StHalf;
          end else begin
            state_d = StIdle;
          end
        end
        StHalf: begin
          if (bus.rolled1) begin
            cap_a_d = bus.dice1;
            got1_d  = 1'b1;
          end
          if (bus.rolled2) begin
            cap_b_d = bus.dice2;
            got2_d  = 1'b1;
          end
          if ((got1_q || bus.rolled1) && (got2_q || bus.rolled2)) begin
            state_d = StEval;
          end else if (bus.rolled1 || bus.rolled2) begin
            cnt_d = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StIdle;
            cap_a_d = '0;
            cap_b_d = '0;
            got1_d  = 1'b0;
            got2_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cap_a_q  <= '0;
      cap_b_q  <= '0;
      got1_q   <= 1'b0;
      got2_q   <= 1'b0;
      cnt_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      sum_q    <= '0;
      dm_q     <= 1'b0;
      rc_q     <= '0;
      drinks_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      got1_q   <= got1_d;
      got2_q   <= got2_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      sum_q    <= sum_d;
      dm_q     <= dm_d;
      rc_q     <= rc_d;
      drinks_q <= drinks_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.event_code  = code_q;
  assign bus.event_valid = valid_q;
  assign bus.sum         = sum_q;
  assign bus.dreimann    = dm_q;
  assign bus.round_cnt   = rc_q;
  assign bus.dm_drinks   = drinks_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dreimann_rules.sv
// Bench for dreimann_rules: directed throws push expected events into a queue; a monitor
// pops and compares every event_valid pulse, including its arrival cycle.
module tb_dreimann_rules;

  localparam int unsigned TO = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    int code;
    int s;
    int dm;
    int rc;
    int dr;
    int at;
  } exp_t;

  exp_t exp_q[$];

  dreimann_rules_if bus ();

  dreimann_rules #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int code, input int s, input int dm, input int rc, input int dr);
    exp_t e;
    e.code = code;
    e.s    = s;
    e.dm   = dm;
    e.rc   = rc;
    e.dr   = dr;
    e.at   = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic throw(input int a, input int b, input int code, input int s, input int dm,
                       input int rc, input int dr);
    bus.dice1   = 3'(a);
    bus.dice2   = 3'(b);
    bus.rolled1 = 1'b1;
    bus.rolled2 = 1'b1;
    expect_ev(code, s, dm, rc, dr);
    tick();
    bus.rolled1 = 1'b0;
    bus.rolled2 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_code"}, int'(bus.event_code), 0);
    chk({tag, "_valid"}, int'(bus.event_valid), 0);
    chk({tag, "_sum"}, int'(bus.sum), 0);
    chk({tag, "_dm"}, int'(bus.dreimann), 0);
    chk({tag, "_rc"}, int'(bus.round_cnt), 0);
    chk({tag, "_drinks"}, int'(bus.dm_drinks), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  // Monitor: every event_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.event_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d at cycle %0d, want no event",
                 bus.event_code, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ev_code", int'(bus.event_code), e.code);
        chk("ev_sum", int'(bus.sum), e.s);
        chk("ev_dreimann", int'(bus.dreimann), e.dm);
        chk("ev_round_cnt", int'(bus.round_cnt), e.rc);
        chk("ev_dm_drinks", int'(bus.dm_drinks), e.dr);
        chk("ev_latency", cyc, e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.dice1    = 3'd0;
    bus.dice2    = 3'd0;
    bus.rolled1  = 1'b0;
    bus.rolled2  = 1'b0;
    bus.new_game = 1'b0;
    #1;
    chk_cleared("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Split throw 3 then 5: new Dreimann
    bus.dice1   = 3'd3;
    bus.rolled1 = 1'b1;
    tick();
    bus.rolled1 = 1'b0;
    tick();
    bus.dice2   = 3'd5;
    bus.rolled2 = 1'b1;
    expect_ev(1, 8, 1, 1, 0);
    tick();
    bus.rolled2 = 1'b0;
    repeat (2) tick();

    throw(1, 2, 2, 3, 1, 2, 1);
    throw(3, 3, 3, 6, 1, 3, 2);
    throw(4, 4, 4, 8, 1, 4, 2);

    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    @(negedge clk);
    chk_cleared("new_game");
    tick();

    throw(3, 4, 1, 7, 1, 1, 0);
    throw(4, 5, 6, 9, 1, 2, 0);
    throw(2, 6, 0, 8, 1, 3, 0);

    // Lone die 1 times out; busy must drop exactly TO cycles after the pulse
    bus.dice1   = 3'd1;
    bus.rolled1 = 1'b1;
    for (int j = 1; j <= int'(TO); j++) begin
      tick();
      bus.rolled1 = 1'b0;
      @(negedge clk);
      chk($sformatf("timeout_busy_%0d", j), int'(bus.busy), (j < int'(TO)) ? 1 : 0);
    end

    // A later lone die 2 opens a new half-throw rather than completing the old one
    bus.dice2   = 3'd2;
    bus.rolled2 = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      bus.rolled2 = 1'b0;
      @(negedge clk);
      chk($sformatf("half2_busy_%0d", j), int'(bus.busy), 1);
      chk($sformatf("half2_valid_%0d", j), int'(bus.event_valid), 0);
    end
    repeat (int'(TO)) tick();
    @(negedge clk);
    chk("half2_timeout_busy", int'(bus.busy), 0);
    tick();

    // Die 1 re-rolled before die 2 arrives: the newer value counts
    bus.dice1   = 3'd2;
    bus.rolled1 = 1'b1;
    tick();
    bus.dice1   = 3'd6;
    tick();
    bus.rolled1 = 1'b0;
    bus.dice2   = 3'd6;
    bus.rolled2 = 1'b1;
    expect_ev(4, 12, 1, 4, 0);
    tick();
    bus.rolled2 = 1'b0;
    repeat (2) tick();

    throw(7, 2, 7, 12, 1, 4, 0);

    // Back-to-back throws every cycle drive round_cnt into saturation
    bus.dice1   = 3'd1;
    bus.dice2   = 3'd1;
    bus.rolled1 = 1'b1;
    bus.rolled2 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      expect_ev(4, 2, 1, (4 + i > 255) ? 255 : 4 + i, 0);
      tick();
    end
    bus.rolled1 = 1'b0;
    bus.rolled2 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("sat_round_cnt", int'(bus.round_cnt), 255);
    tick();

    // new_game beats rolled pulses in the same cycle
    bus.dice1    = 3'd3;
    bus.dice2    = 3'd3;
    bus.rolled1  = 1'b1;
    bus.rolled2  = 1'b1;
    bus.new_game = 1'b1;
    tick();
    bus.rolled1  = 1'b0;
    bus.rolled2  = 1'b0;
    bus.new_game = 1'b0;
    @(negedge clk);
    chk_cleared("ng_roll");
    tick();
    @(negedge clk);
    chk("ng_roll_busy2", int'(bus.busy), 0);
    chk("ng_roll_valid2", int'(bus.event_valid), 0);
    tick();

    // Asynchronous reset while a half-throw is pending
    throw(3, 5, 1, 8, 1, 1, 0);
    bus.dice1   = 3'd4;
    bus.rolled1 = 1'b1;
    tick();
    bus.rolled1 = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
